// File: rtl/fetch_unit_if.sv
// Memory read port between the fetch stage (master) and the shared memory (slave).
// Request/acknowledge handshake; read data is valid in the acknowledge cycle.
interface fetch_unit_if;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;

    modport master (output memReq, output memAddr, input memAck, input memRdata);
    modport slave  (input memReq, input memAddr, output memAck, output memRdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, memory read handshake and
// next-PC selection (sequential / branch / jump / jump-register) with alignment trap.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               fetchStart,
    input  logic               pcWrite,
    input  logic [1:0]         pcSel,
    input  logic [31:0]        sxi,
    input  logic [27:0]        jAddr,
    input  logic [31:0]        jrTarget,
    fetch_unit_if.master       mem,
    output logic [31:0]        instr,
    output logic               instrValid,
    output logic [31:0]        pc,
    output logic [31:0]        pcPlus4,
    output logic               busy,
    output logic               alignErr
);

    typedef enum logic { IDLE = 1'b0, REQ = 1'b1 } state_t;

    state_t      state_q;
    logic        memReq_q;
    logic [31:0] memAddr_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        alignErr_q;
    logic [31:0] npc;
    logic [31:0] brOff;

    assign pcPlus4 = pc_q + 32'd4;
    assign brOff   = sxi << 2;

    always_comb begin
        npc = pcPlus4;
        case (pcSel)
            2'd0: npc = pcPlus4;
            2'd1: npc = pcPlus4 + brOff;
            2'd2: npc = {pcPlus4[31:28], jAddr};
            2'd3: npc = jrTarget;
            default: npc = pcPlus4;
        endcase
    end

    // Misaligned targets are truncated to the word below and flagged.
    assign pc_d = {npc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memAddr_q  <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            alignErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (fetchStart) begin
                    // Old pc is captured even when pcWrite fires this same edge.
                    memAddr_q <= pc_q;
                    valid_q   <= 1'b0;
                    memReq_q  <= 1'b1;
                    state_q   <= REQ;
                end
                REQ: if (mem.memAck) begin
                    instr_q  <= mem.memRdata;
                    valid_q  <= 1'b1;
                    memReq_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (pcWrite) begin
                pc_q <= pc_d;
                if (npc[1:0] != 2'b00) alignErr_q <= 1'b1;
            end
        end
    end

    assign mem.memReq  = memReq_q;
    assign mem.memAddr = memAddr_q;
    assign busy        = memReq_q;
    assign instr       = instr_q;
    assign instrValid  = valid_q;
    assign pc          = pc_q;
    assign alignErr    = alignErr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test-plan steps followed by random cycles, all checked every cycle
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        fetchStart = 1'b0;
    logic        pcWrite = 1'b0;
    logic [1:0]  pcSel = 2'd0;
    logic [31:0] sxi = 32'h0;
    logic [27:0] jAddr = 28'h0;
    logic [31:0] jrTarget = 32'h0;
    logic [31:0] instr, pc, pcPlus4;
    logic        instrValid, busy, alignErr;

    fetch_unit_if mif ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstN(rstN), .fetchStart(fetchStart), .pcWrite(pcWrite),
        .pcSel(pcSel), .sxi(sxi), .jAddr(jAddr), .jrTarget(jrTarget), .mem(mif),
        .instr(instr), .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4),
        .busy(busy), .alignErr(alignErr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int txns = 0;

    logic [31:0] m_pc, m_addr, m_instr;
    logic        m_busy, m_valid, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0;
        m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_all();
        chk("memReq",     {31'h0, mif.memReq}, {31'h0, m_busy});
        chk("busy",       {31'h0, busy},       {31'h0, m_busy});
        chk("memAddr",    mif.memAddr,         m_addr);
        chk("pc",         pc,                  m_pc);
        chk("pcPlus4",    pcPlus4,             m_pc + 32'd4);
        chk("instr",      instr,               m_instr);
        chk("instrValid", {31'h0, instrValid}, {31'h0, m_valid});
        chk("alignErr",   {31'h0, alignErr},   {31'h0, m_err});
    endtask

    // One clock: advance the model with the inputs held across the edge, then compare.
    task automatic step();
        logic [31:0] tgt;
        @(posedge clk);
        if (rstN) begin
            if (!m_busy && fetchStart) begin
                m_addr = m_pc; m_valid = 1'b0; m_busy = 1'b1;
            end else if (m_busy && mif.memAck) begin
                m_instr = mif.memRdata; m_valid = 1'b1; m_busy = 1'b0; txns++;
            end
            if (pcWrite) begin
                case (pcSel)
                    2'd0: tgt = m_pc + 4;
                    2'd1: tgt = m_pc + 4 + sxi * 4;
                    2'd2: tgt = ((m_pc + 4) & 32'hF000_0000) + {4'h0, jAddr};
                    default: tgt = jrTarget;
                endcase
                if (tgt % 4 != 0) m_err = 1'b1;
                m_pc = tgt & ~32'd3;
            end
        end
        #1 check_all();
    endtask

    task automatic idle_in();
        fetchStart = 1'b0; pcWrite = 1'b0; mif.memAck = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        idle_in(); pcWrite = 1'b1; pcSel = 2'd3; jrTarget = v; step(); pcWrite = 1'b0;
    endtask

    int t0;
    logic [31:0] keep;

    initial begin
        mif.memAck = 1'b0; mif.memRdata = 32'h0;
        model_reset();
        #1 check_all();
        step(); step();
        rstN = 1'b1;
        step();

        // fetch-and-increment with zero-wait memory
        fetchStart = 1'b1; pcWrite = 1'b1; pcSel = 2'd0; step();
        chk("tp1_addr", mif.memAddr, 32'h0);
        chk("tp1_pc", pc, 32'h4);
        idle_in(); mif.memAck = 1'b1; mif.memRdata = 32'h8C22_0004; step();
        chk("tp1_instr", instr, 32'h8C22_0004);
        chk("tp1_valid", {31'h0, instrValid}, 32'h1);

        // wait states with a jump written mid-request
        set_pc(32'h0);
        fetchStart = 1'b1; step(); fetchStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pcWrite = (i == 1); pcSel = 2'd2; jAddr = 28'h0000_100;
            step();
            chk("tp2_req", {31'h0, mif.memReq}, 32'h1);
            chk("tp2_addr", mif.memAddr, 32'h0);
        end
        pcWrite = 1'b0;
        chk("tp2_pc", pc, 32'h0000_0100);
        mif.memAck = 1'b1; mif.memRdata = 32'h1234_5678; step(); idle_in();

        // negative branch
        set_pc(32'h0000_0010);
        pcWrite = 1'b1; pcSel = 2'd1; sxi = 32'hFFFF_FFFE; step(); pcWrite = 1'b0;
        chk("tp3_pc", pc, 32'h0000_000C);

        // misaligned JR, sticky error
        set_pc(32'h0000_0203);
        chk("tp4_pc", pc, 32'h0000_0200);
        chk("tp4_err", {31'h0, alignErr}, 32'h1);
        pcWrite = 1'b1; pcSel = 2'd0; step(); step(); pcWrite = 1'b0;
        chk("tp4_sticky", {31'h0, alignErr}, 32'h1);

        // fetchStart during REQ and memAck during IDLE are ignored
        t0 = txns;
        fetchStart = 1'b1; step();
        fetchStart = 1'b1; step();
        fetchStart = 1'b0; mif.memAck = 1'b1; mif.memRdata = 32'hCAFE_0001; step();
        mif.memRdata = 32'hDEAD_0002; step(); step();
        idle_in();
        chk("tp5_txns", txns - t0, 32'd1);
        chk("tp5_instr", instr, 32'hCAFE_0001);
        chk("tp5_idle", {31'h0, mif.memReq}, 32'h0);

        // asynchronous reset mid-request
        fetchStart = 1'b1; step(); fetchStart = 1'b0;
        chk("tp6_req", {31'h0, mif.memReq}, 32'h1);
        #2 rstN = 1'b0;
        #1;
        chk("tp6_req_drop", {31'h0, mif.memReq}, 32'h0);
        chk("tp6_pc", pc, 32'h0);
        chk("tp6_valid", {31'h0, instrValid}, 32'h0);
        model_reset();
        mif.memAck = 1'b1; mif.memRdata = 32'hBAD0_BAD0; step();
        rstN = 1'b1; step(); step();
        chk("tp6_late_ack", instr, 32'h0);
        idle_in();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            fetchStart    = ($urandom_range(0, 2) == 0);
            pcWrite       = ($urandom_range(0, 2) == 0);
            pcSel         = 2'($urandom_range(0, 3));
            sxi           = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            jAddr         = 28'($urandom);
            jrTarget      = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);
            mif.memAck    = ($urandom_range(0, 2) == 0);
            mif.memRdata  = $urandom;
            step();
        end
        keep = m_pc;
        idle_in(); step();
        chk("rand_pc_hold", pc, keep);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle MIPS core. It holds the program counter and the instruction register. It issues word reads to the shared memory port through a request/acknowledge handshake. It delivers the latched instruction to the decoder, and it computes the next PC from the sequential, branch, jump and jump-register sources selected by the control FSM.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- fetchStart  in  1  FSM request to fetch the instruction at the current pc.
- pcWrite  in  1  FSM strobe: load pc with the next-PC source chosen by pcSel.
- pcSel  in  2  next-PC source: 0 = pcPlus4, 1 = branch, 2 = jump, 3 = jrTarget.
- sxi  in  32  sign-extended immediate from the decoder (branch offset, in words).
- jAddr  in  28  jump target from the decoder, already shifted left by 2.
- jrTarget  in  32  register value for JR.
- memReq  out  1  memory read request.
- memAddr  out  32  read address; stable while memReq = 1.
- memAck  in  1  memory acknowledge; memRdata is valid in the same cycle.
- memRdata  in  32  read data.
- instr  out  32  instruction register; feeds the decoder.
- instrValid  out  1  instr holds the word for the most recently accepted fetch.
- pc  out  32  current program counter.
- pcPlus4  out  32  pc + 4 (combinational).
- busy  out  1  fetch in progress (state REQ).
- alignErr  out  1  sticky: a misaligned next PC was written.

## Operation
- State machine with two states, IDLE and REQ.
  - IDLE: memReq = 0. If fetchStart = 1, capture pc into memAddr, clear instrValid, and go to REQ.
  - REQ: memReq = 1 and busy = 1. If memAck = 1, load memRdata into instr, set instrValid = 1, and go to IDLE. Otherwise stay in REQ.
- fetchStart in REQ is ignored (no queuing).
- memAck in IDLE is ignored; instr is unchanged.
- memAddr is a registered copy of the pc captured at acceptance. A pcWrite during REQ updates pc but not memAddr.
- Next-PC selection, all arithmetic 32-bit modulo 2^32:
  - sel 0: pc + 4.
  - sel 1: pc + 4 + (sxi << 2), shifted result truncated to 32 bits.
  - sel 2: {pcPlus4[31:28], jAddr}.
  - sel 3: jrTarget.
- pcWrite = 1 loads the selected value at the edge, in any state.
- Alignment: if bits [1:0] of the selected value are nonzero, pc is loaded with bits [1:0] forced to 0 and alignErr is set. alignErr clears only on reset.
- fetchStart and pcWrite in the same cycle: the fetch address is the pre-update pc, and pc takes the new value. This allows the fetch-and-increment done in a single cycle.

## Timing
- Reset (asynchronous, rstN = 0):
  - State IDLE, pc = RESET_PC, memAddr = RESET_PC.
  - memReq = 0, busy = 0, instr = 0, instrValid = 0, alignErr = 0.
  - Outputs take these values immediately, not at the next edge.
- Reset asserted during REQ: memReq drops at once and the outstanding fetch is abandoned. A memAck arriving after release is ignored.
- Fetch latency:
  - fetchStart sampled at edge E0 → memReq = 1 from E0 until the acknowledging edge.
  - memAck sampled high at edge E1 (E1 ≥ E0 + 1) → instr and instrValid updated after E1, and memReq = 0 after E1.
  - Zero-wait memory gives instrValid one cycle after the request cycle.
- Back-to-back fetches: fetchStart in the cycle after the ack edge is accepted, so there is no dead cycle beyond the IDLE state.
- pc and alignErr update at the edge on which pcWrite is sampled. pcPlus4 follows pc combinationally.
- instrValid stays 1 until the next accepted fetchStart or reset.

## Test plan
- Reset, then fetchStart + pcWrite (sel 0) with zero-wait memAck and memRdata = 32'h8C22_0004 → memAddr = 0, pc = 4, instr = 32'h8C22_0004, instrValid = 1.
- Wait states: memAck held low for 3 cycles while pcWrite (sel 2, jAddr = 28'h0000_100) fires mid-REQ → memReq and memAddr stay constant at 0 for 4 cycles, then pc = 32'h0000_0100.
- Branch: pc = 32'h0000_0010, sxi = 32'hFFFF_FFFE, sel 1 → pc = 32'h0000_000C.
- JR misaligned: jrTarget = 32'h0000_0203, sel 3 → pc = 32'h0000_0200, alignErr = 1 and stays 1 after further aligned writes.
- fetchStart pulsed during REQ and memAck pulsed during IDLE → exactly one memory transaction, and instr updated only once.
- rstN low mid-REQ → memReq = 0 immediately, pc = RESET_PC, instrValid = 0; a late memAck leaves instr = 0.
